// File: rtl/obi_reg_bridge.sv
// obi_reg_bridge: single-outstanding OBI subordinate to regbus bridge with
// a cycle-bounded abort so a hung register device cannot stall the bus.

package obi_reg_bridge_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  aid;
    logic        a_optional;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  rid;
    logic        err;
    logic        r_optional;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module obi_reg_bridge
  import obi_reg_bridge_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255,
  parameter logic [31:0] ErrData       = 32'hBADC_AB1E
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t obi_req_i,
  output sbr_obi_rsp_t obi_rsp_o,
  output reg_req_t     reg_req_o,
  input  reg_rsp_t     reg_rsp_i,
  output logic         timeout_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  // Abort fires in the TimeoutCycles-th ACCESS cycle (counter starts at 0).
  localparam bit          TimeoutEn = (TimeoutCycles != 0);
  localparam logic [15:0] CntLim    = 16'(TimeoutCycles - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  aid_q, aid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hs;

  // a_optional carries no meaning for register devices.
  logic unused_a_optional;
  assign unused_a_optional = obi_req_i.a.a_optional;

  // Next-state, capture and output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aid_d     = aid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    timeout_o = 1'b0;

    // Grant only when no access is pending on the device side.
    hs = obi_req_i.req & ((state_q == IDLE) | (state_q == RESP));

    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = hs;
    obi_rsp_o.rvalid       = (state_q == RESP);
    obi_rsp_o.r.rdata      = rdata_q;
    obi_rsp_o.r.rid        = aid_q;
    obi_rsp_o.r.err        = err_q;
    obi_rsp_o.r.r_optional = 1'b0;

    reg_req_o.valid = (state_q == ACCESS);
    reg_req_o.addr  = addr_q;
    reg_req_o.write = we_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = we_q ? be_q : 4'b0000;

    case (state_q)
      ACCESS: begin
        if (reg_rsp_i.ready) begin
          rdata_d = we_q ? 32'h0 : reg_rsp_i.rdata;
          err_d   = reg_rsp_i.error;
          state_d = RESP;
        end else if (TimeoutEn && (cnt_q == CntLim)) begin
          // Deliberate protocol break: valid drops without ready.
          rdata_d   = ErrData;
          err_d     = 1'b1;
          timeout_o = 1'b1;
          state_d   = RESP;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        // IDLE and RESP both accept a new request; RESP lasts one cycle.
        state_d = IDLE;
        if (hs) begin
          addr_d  = obi_req_i.a.addr;
          we_d    = obi_req_i.a.we;
          be_d    = obi_req_i.a.be;
          wdata_d = obi_req_i.a.wdata;
          aid_d   = obi_req_i.a.aid;
          cnt_d   = 16'd0;
          state_d = ACCESS;
        end
      end
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      aid_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      aid_q   <= aid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
